// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode type, default 640x480 timing and bar palette
package vga_pkg;

  typedef enum logic [1:0] {
    VBARS   = 2'd0,
    HBARS   = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // {R,G,B} on/off flags for a bar index; bit 2 drives red, bit 0 blue
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b000;
      3'd1:    c = 3'b001;
      3'd2:    c = 3'b010;
      3'd3:    c = 3'b011;
      3'd4:    c = 3'b100;
      3'd5:    c = 3'b101;
      3'd6:    c = 3'b110;
      default: c = 3'b111;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters with active, sync and frame-boundary decode
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hs_n,
  output logic          o_vs_n,
  output logic          o_frame_first,
  output logic          o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

  // Pixel counter runs every clock; line counter steps on each line wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_active      = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign o_hs_n        = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                           (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vs_n        = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                           (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_end   = w_h_last && w_v_last;

endmodule

// File: rtl/vga_pattern_engine.sv
// rtl/vga_pattern_engine.sv - VGA timing plus run-time selectable test patterns
module vga_pattern_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int NUM_BARS   = 8,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                   i_clk_25,
  input  logic                   i_rst,
  input  logic [1:0]             i_mode,
  input  logic [3*COLOR_W-1:0]   i_solid_rgb,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_video_on,
  output logic                   o_synch,
  output logic [COLOR_W-1:0]     o_red,
  output logic [COLOR_W-1:0]     o_green,
  output logic [COLOR_W-1:0]     o_blue,
  output logic                   o_frame_start,
  output logic [15:0]            o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0]          w_h_cnt;
  logic [VW-1:0]          w_v_cnt;
  logic                   w_active;
  logic                   w_hs_n;
  logic                   w_vs_n;
  logic                   w_frame_first;
  logic                   w_frame_end;
  logic [3*COLOR_W-1:0]   w_pix;

  mode_e                  r_act_mode;
  logic [3*COLOR_W-1:0]   r_act_rgb;
  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_video_on;
  logic [3*COLOR_W-1:0]   r_pix;
  logic                   r_frame_start;
  logic [15:0]            r_frame_count;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .i_clk         (i_clk_25),
    .i_rst         (i_rst),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_active      (w_active),
    .o_hs_n        (w_hs_n),
    .o_vs_n        (w_vs_n),
    .o_frame_first (w_frame_first),
    .o_frame_end   (w_frame_end)
  );

  // Bar number mod 8 by counting constant boundaries ceil(k*span/NUM_BARS);
  // the 3-bit counter wraps so bars beyond 8 reuse the palette
  function automatic logic [2:0] bar_index(input int pos, input int span);
    logic [2:0] bar;
    bar = 3'd0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (pos >= (k * span + NUM_BARS - 1) / NUM_BARS) bar = bar + 3'd1;
    end
    return bar;
  endfunction

  function automatic logic [3*COLOR_W-1:0] expand(input logic [2:0] f);
    return {{COLOR_W{f[2]}}, {COLOR_W{f[1]}}, {COLOR_W{f[0]}}};
  endfunction

  // Mode and solid colour take effect only at the last pixel of a frame
  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      r_act_mode <= VBARS;
      r_act_rgb  <= '0;
    end else if (w_frame_end) begin
      r_act_mode <= mode_e'(i_mode);
      r_act_rgb  <= i_solid_rgb;
    end
  end

  // Pattern mux for the current counter position; blank outside the active area
  always_comb begin
    w_pix = '0;
    case (r_act_mode)
      VBARS:   w_pix = expand(bar_color(bar_index(int'(w_h_cnt), H_ACTIVE)));
      HBARS:   w_pix = expand(bar_color(bar_index(int'(w_v_cnt), V_ACTIVE)));
      CHECKER: w_pix = (w_h_cnt[CHECK_LOG2] ^ w_v_cnt[CHECK_LOG2]) ? '1 : '0;
      SOLID:   w_pix = r_act_rgb;
    endcase
    if (!w_active) w_pix = '0;
  end

  // Single output register stage so sync, blank and colour stay aligned
  always_ff @(posedge i_clk_25) begin
    if (i_rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_pix         <= '0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hsync       <= w_hs_n;
      r_vsync       <= w_vs_n;
      r_video_on    <= w_active;
      r_pix         <= w_pix;
      r_frame_start <= w_frame_first;
      if (w_frame_first) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_synch       = 1'b0;
  assign o_red         = r_pix[3*COLOR_W-1:2*COLOR_W];
  assign o_green       = r_pix[2*COLOR_W-1:COLOR_W];
  assign o_blue        = r_pix[COLOR_W-1:0];
  assign o_frame_start = r_frame_start;
  assign o_frame_count = r_frame_count;

endmodule
